// File: rtl/fetch_pkg.sv
// Shared widths, opcode constants and controller state type for the instruction fetch slice.
package fetch_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int OP_W   = 6;

   localparam logic [OP_W-1:0] HALT_OP = 6'b111111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FETCH = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ISSUE = 3'd4,
      ST_HALT  = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Loader, run-control and instruction-memory signals shared by the fetch controller and its environment.
interface instr_fetch_ctrl_if;
   import fetch_pkg::*;

   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ack;
   logic              run;
   logic [ADDR_W-1:0] start_addr;
   logic              stall;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic [OP_W-1:0]   ir_op_code;
   logic [ADDR_W-1:0] im_addr;
   logic              im_en_write;
   logic [DATA_W-1:0] im_data_in;
   logic              ir_load;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc;
   logic              halted;

   modport master (
      input  ld_req, ld_addr, ld_data, run, start_addr, stall, br_taken, br_target, ir_op_code,
      output ld_ack, im_addr, im_en_write, im_data_in, ir_load, instr_valid, pc, halted
   );

   modport slave (
      output ld_req, ld_addr, ld_data, run, start_addr, stall, br_taken, br_target, ir_op_code,
      input  ld_ack, im_addr, im_en_write, im_data_in, ir_load, instr_valid, pc, halted
   );

endinterface

// File: rtl/pc_counter.sv
// Program counter with load, wrapping increment and hold; exposes the next value so the
// controller can register the IM address in step with the PC.
module pc_counter
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc_r,
   output logic [ADDR_W-1:0] pc_nxt_s
);

   // Next PC: load wins over increment; the add wraps naturally at 10 bits.
   always_comb begin
      pc_nxt_s = pc_r;
      if (load_en) begin
         pc_nxt_s = load_addr;
      end else if (inc_en) begin
         pc_nxt_s = pc_r + 10'd1;
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pc_r <= {ADDR_W{1'b0}};
      end else begin
         pc_r <= pc_nxt_s;
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Moore fetch controller: loads instruction memory, then fetches, waits one read cycle,
// captures into IR and issues, with stall, branch and halt handling.
module instr_fetch_ctrl
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_b,
   instr_fetch_ctrl_if.master bus
);

   fetch_state_e      state_r;
   fetch_state_e      state_nxt_s;
   logic              pc_load_s;
   logic              pc_inc_s;
   logic [ADDR_W-1:0] pc_target_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_nxt_s;

   logic              ld_ack_r;
   logic              im_en_write_r;
   logic [ADDR_W-1:0] im_addr_r;
   logic [DATA_W-1:0] im_data_in_r;
   logic              ir_load_r;
   logic              instr_valid_r;
   logic              halted_r;

   pc_counter u_pc_counter (
      .clk       (clk),
      .rst_b     (rst_b),
      .load_en   (pc_load_s),
      .load_addr (pc_target_s),
      .inc_en    (pc_inc_s),
      .pc_r      (pc_r),
      .pc_nxt_s  (pc_nxt_s)
   );

   // Next-state and PC-control decode.
   always_comb begin
      state_nxt_s = state_r;
      pc_load_s   = 1'b0;
      pc_inc_s    = 1'b0;
      pc_target_s = {ADDR_W{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (bus.ld_req) begin
               state_nxt_s = ST_LOAD;
            end else if (bus.run) begin
               state_nxt_s = ST_FETCH;
               pc_load_s   = 1'b1;
               pc_target_s = bus.start_addr;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (bus.ld_req) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            pc_inc_s    = 1'b1;
            state_nxt_s = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (bus.stall) begin
               state_nxt_s = ST_ISSUE;
            end else if (bus.ir_op_code == HALT_OP) begin
               state_nxt_s = ST_HALT;
            end else begin
               // A dropped run still lets a taken branch redirect the PC before parking.
               if (bus.br_taken) begin
                  pc_load_s   = 1'b1;
                  pc_target_s = bus.br_target;
               end else begin
                  pc_load_s   = 1'b0;
               end
               if (bus.run) begin
                  state_nxt_s = ST_FETCH;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
         end
         ST_HALT: begin
            if (bus.ld_req) begin
               state_nxt_s = ST_LOAD;
            end else if (!bus.run) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HALT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Output registers load the values belonging to the state being entered.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ld_ack_r      <= 1'b0;
         im_en_write_r <= 1'b0;
         im_addr_r     <= {ADDR_W{1'b0}};
         im_data_in_r  <= {DATA_W{1'b0}};
         ir_load_r     <= 1'b0;
         instr_valid_r <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         ld_ack_r      <= (state_nxt_s == ST_LOAD);
         im_en_write_r <= (state_nxt_s == ST_LOAD);
         im_addr_r     <= (state_nxt_s == ST_LOAD) ? bus.ld_addr : pc_nxt_s;
         im_data_in_r  <= (state_nxt_s == ST_LOAD) ? bus.ld_data : {DATA_W{1'b0}};
         ir_load_r     <= (state_nxt_s == ST_WAIT);
         instr_valid_r <= (state_nxt_s == ST_ISSUE);
         halted_r      <= (state_nxt_s == ST_HALT);
      end
   end

   assign bus.ld_ack      = ld_ack_r;
   assign bus.im_en_write = im_en_write_r;
   assign bus.im_addr     = im_addr_r;
   assign bus.im_data_in  = im_data_in_r;
   assign bus.ir_load     = ir_load_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.pc          = pc_r;
   assign bus.halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: behavioural IM and IR around the DUT, directed scenarios then
// a randomized program walk checked against an address-sequence reference model.
module tb_instr_fetch_ctrl;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst_b;
   int   tests = 0;
   int   fails = 0;

   instr_fetch_ctrl_if bus ();

   instr_fetch_ctrl dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:1023];
   logic [15:0] rdata;
   logic [15:0] ir;
   logic [15:0] model_mem [0:1023];

   always @(posedge clk) begin
      if (bus.im_en_write) mem[bus.im_addr] <= bus.im_data_in;
      rdata <= mem[bus.im_addr];
   end

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) ir <= 16'h0000;
      else if (bus.ir_load) ir <= rdata;
   end

   assign bus.ir_op_code = ir[15:10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack"},   {31'd0, bus.ld_ack}, 32'd0);
      chk({tag, "_we"},    {31'd0, bus.im_en_write}, 32'd0);
      chk({tag, "_addr"},  {22'd0, bus.im_addr}, 32'd0);
      chk({tag, "_din"},   {16'd0, bus.im_data_in}, 32'd0);
      chk({tag, "_irld"},  {31'd0, bus.ir_load}, 32'd0);
      chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
      chk({tag, "_pc"},    {22'd0, bus.pc}, 32'd0);
      chk({tag, "_halt"},  {31'd0, bus.halted}, 32'd0);
   endtask

   task automatic load_word(input logic [9:0] a, input logic [15:0] d);
      bus.ld_req  = 1'b1;
      bus.ld_addr = a;
      bus.ld_data = d;
      tick();
      chk("load_ack",  {31'd0, bus.ld_ack}, 32'd1);
      chk("load_we",   {31'd0, bus.im_en_write}, 32'd1);
      chk("load_addr", {22'd0, bus.im_addr}, {22'd0, a});
      chk("load_data", {16'd0, bus.im_data_in}, {16'd0, d});
      model_mem[a] = d;
   endtask

   task automatic end_load();
      bus.ld_req = 1'b0;
      tick();
      chk("load_end_ack", {31'd0, bus.ld_ack}, 32'd0);
      chk("load_end_we",  {31'd0, bus.im_en_write}, 32'd0);
   endtask

   task automatic noise(input bit en);
      if (en) begin
         bus.ld_req  = 1'($urandom);
         bus.ld_addr = 10'($urandom);
         bus.ld_data = 16'($urandom);
         chk("ld_ignored", {30'd0, bus.ld_ack, bus.im_en_write}, 32'd0);
      end
   endtask

   // Executes one instruction at address a; reports the model's next fetch address and halt.
   task automatic exec_instr(input logic [9:0] a, input int nstall, input bit br,
                             input logic [9:0] tgt, input bit nz,
                             output logic [9:0] next_a, output bit halt_o);
      bit          got;
      logic [9:0]  a1;
      logic [15:0] w;
      got = 1'b0;
      a1  = a + 10'd1;
      w   = model_mem[a];
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         got = (bus.ir_load === 1'b1);
         if (!got) noise(nz);
      end
      chk("ir_load_seen", {31'd0, got}, 32'd1);
      chk("fetch_addr", {22'd0, bus.im_addr}, {22'd0, a});
      chk("wait_pc",    {22'd0, bus.pc}, {22'd0, a});
      noise(nz);
      tick();
      chk("issue_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("issue_irld",  {31'd0, bus.ir_load}, 32'd0);
      chk("issue_pc",    {22'd0, bus.pc}, {22'd0, a1});
      chk("issue_op",    {26'd0, bus.ir_op_code}, {26'd0, w[15:10]});
      bus.stall = 1'b1;
      for (int k = 0; k < nstall; k++) begin
         bus.br_taken  = 1'($urandom);
         bus.br_target = 10'($urandom);
         noise(nz);
         tick();
         chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
         chk("stall_pc",    {22'd0, bus.pc}, {22'd0, a1});
      end
      bus.stall = 1'b0;
      if (w[15:10] == 6'b111111) begin
         bus.br_taken = 1'b0;
         tick();
         chk("halt_flag", {31'd0, bus.halted}, 32'd1);
         chk("halt_pc",   {22'd0, bus.pc}, {22'd0, a1});
         next_a = a1;
         halt_o = 1'b1;
      end else begin
         bus.br_taken  = br;
         bus.br_target = tgt;
         tick();
         bus.br_taken = 1'b0;
         next_a = br ? tgt : a1;
         halt_o = 1'b0;
         chk("next_addr",  {22'd0, bus.im_addr}, {22'd0, next_a});
         chk("left_issue", {31'd0, bus.instr_valid}, 32'd0);
      end
      bus.ld_req = 1'b0;
   endtask

   initial begin
      logic [9:0]  na;
      logic [9:0]  a;
      logic [5:0]  op;
      bit          h;
      int          seen;
      rst_b          = 1'b1;
      bus.ld_req     = 1'b0;
      bus.ld_addr    = 10'd0;
      bus.ld_data    = 16'd0;
      bus.run        = 1'b0;
      bus.start_addr = 10'd0;
      bus.stall      = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = 10'd0;
      #2 rst_b = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk) rst_b = 1'b1;

      // Directed program load: four words, then two more including a halt at 5.
      load_word(10'd0, 16'h040D);
      load_word(10'd1, 16'h280C);
      load_word(10'd2, 16'h2C14);
      load_word(10'd3, 16'h080D);
      end_load();
      load_word(10'd4, 16'h0000);
      load_word(10'd5, 16'hFC00);
      end_load();

      // Run from 0, stall and branch at 2, halt at 5.
      bus.run = 1'b1;
      bus.start_addr = 10'd0;
      exec_instr(10'd0, 0, 1'b0, 10'd0, 1'b0, na, h);
      exec_instr(na,    0, 1'b0, 10'd0, 1'b0, na, h);
      exec_instr(na,    3, 1'b1, 10'd3, 1'b0, na, h);
      chk("branch_target", {22'd0, na}, 32'd3);
      exec_instr(na,    0, 1'b0, 10'd0, 1'b0, na, h);
      exec_instr(na,    0, 1'b0, 10'd0, 1'b0, na, h);
      exec_instr(na,    0, 1'b0, 10'd0, 1'b0, na, h);
      chk("halt_reached", {31'd0, h}, 32'd1);
      tick();
      chk("halt_frozen_pc", {22'd0, bus.pc}, 32'd6);
      chk("halt_held",      {31'd0, bus.halted}, 32'd1);

      // HALT -> LOAD, then wrap through 1023 and drop run mid-instruction.
      load_word(10'd1023, 16'h0401);
      chk("halt_to_load_halted", {31'd0, bus.halted}, 32'd0);
      bus.run = 1'b0;
      end_load();
      bus.run = 1'b1;
      bus.start_addr = 10'd1023;
      exec_instr(10'd1023, 0, 1'b0, 10'd0, 1'b0, na, h);
      chk("wrap_next", {22'd0, na}, 32'd0);
      bus.run = 1'b0;
      exec_instr(na, 1, 1'b0, 10'd0, 1'b0, na, h);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.ir_load === 1'b1) seen++;
      end
      chk("run_drop_idle", seen, 32'd0);

      // ld_req and run together in IDLE: loading wins.
      bus.run = 1'b1;
      load_word(10'd6, 16'h0400);
      bus.run = 1'b0;
      end_load();

      // Reset during WAIT, then run straight out of reset into the halt at 5.
      bus.run = 1'b1;
      bus.start_addr = 10'd2;
      tick();
      tick();
      chk("pre_reset_irld", {31'd0, bus.ir_load}, 32'd1);
      #2 rst_b = 1'b0;
      #1 check_all_zero("midreset");
      bus.start_addr = 10'd5;
      @(negedge clk) rst_b = 1'b1;
      tick();
      chk("first_edge_fetch", {22'd0, bus.im_addr}, 32'd5);
      exec_instr(10'd5, 0, 1'b0, 10'd0, 1'b0, na, h);
      chk("halt_after_reset", {31'd0, h}, 32'd1);
      bus.run = 1'b0;
      tick();
      chk("halt_to_idle", {31'd0, bus.halted}, 32'd0);

      // Random program over 0..31, walked with random stalls, branches and ignored loads.
      for (int i = 0; i < 32; i++) begin
         op = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 62));
         load_word(10'(i), {op, 10'($urandom)});
      end
      end_load();
      a = 10'($urandom_range(0, 31));
      bus.start_addr = a;
      bus.run = 1'b1;
      for (int n = 0; n < 40; n++) begin
         exec_instr(a, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) || (a == 10'd31),
                    10'($urandom_range(0, 31)), 1'b1, na, h);
         if (h) begin
            bus.run = 1'b0;
            tick();
            chk("rand_halt_idle", {31'd0, bus.halted}, 32'd0);
            a = 10'($urandom_range(0, 31));
            bus.start_addr = a;
            bus.run = 1'b1;
         end else begin
            a = na;
         end
      end
      bus.run = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
